// File: rtl/radio_enable_seq.sv
// Per-channel radio enable / RX-enable sequencer with warm-up and cool-down ordering.
// Enable always leads RX-enable on power-up and trails it on power-down; isolateM1 forces all-off.
module radio_enable_seq #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned WARMUP_CYC   = 4,
  parameter int unsigned COOLDOWN_CYC = 2
) (
  input  logic              ck,
  input  logic              arst,
  input  logic              isolateM1,
  input  logic [NUM_CH-1:0] en_req,
  input  logic [NUM_CH-1:0] rx_req,
  input  logic [NUM_CH-1:0] err_clr,
  output logic [NUM_CH-1:0] radio_enable,
  output logic [NUM_CH-1:0] radio_rx_en,
  output logic [NUM_CH-1:0] ch_ready,
  output logic [NUM_CH-1:0] seq_err
);

  localparam int unsigned MAX_CYC = (WARMUP_CYC > COOLDOWN_CYC) ? WARMUP_CYC : COOLDOWN_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WARM = 2'd1,
    ST_ON   = 2'd2,
    ST_COOL = 2'd3
  } state_t;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             en_q;
    logic             rx_q;
    logic             rdy_q;
    logic             err_q;
    logic             err_set_c;

    // State and counter register
    always_ff @(posedge ck) begin
      if (arst) begin
        state_q <= ST_OFF;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next-state: isolation overrides the sequence; cool-down is never cut short by en_req
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (isolateM1) begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          ST_OFF: begin
            if (en_req[g]) begin
              state_d = ST_WARM;
              cnt_d   = WARM_LOAD;
            end
          end
          ST_WARM: begin
            if (!en_req[g]) begin
              state_d = ST_COOL;
              cnt_d   = COOL_LOAD;
            end else if (cnt_q == '0) begin
              state_d = ST_ON;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          ST_ON: begin
            if (!en_req[g]) begin
              state_d = ST_COOL;
              cnt_d   = COOL_LOAD;
            end
          end
          ST_COOL: begin
            if (cnt_q == '0) begin
              state_d = ST_OFF;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          default: begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end
        endcase
      end
    end

    assign err_set_c = rx_req[g] & ~en_req[g] & ~isolateM1;

    // Outputs decoded from the next state so they line up with the state register
    always_ff @(posedge ck) begin
      if (arst) begin
        en_q  <= 1'b0;
        rx_q  <= 1'b0;
        rdy_q <= 1'b0;
        err_q <= 1'b0;
      end else begin
        en_q  <= (state_d != ST_OFF);
        rx_q  <= (state_d == ST_ON) & rx_req[g];
        rdy_q <= (state_d == ST_ON);
        if (err_set_c) begin
          err_q <= 1'b1;
        end else if (err_clr[g]) begin
          err_q <= 1'b0;
        end
      end
    end

    assign radio_enable[g] = en_q;
    assign radio_rx_en[g]  = rx_q;
    assign ch_ready[g]     = rdy_q;
    assign seq_err[g]      = err_q;
  end

endmodule
